tiny_nn_ctrl: RTL and testbench
===============================

# tiny_nn_ctrl

Parametrised command sequencer for the tiny-nn datapath. It decodes 16-bit command words from the shared input bus and drives the control inputs of the value/parameter array core for any array height (≥2) and width. It serialises the core's 16-bit accumulate result onto the 8-bit output bus. New over the previous top-level: arbitrary row count, a parameter-keep mode that skips reloading, and an optional ReLU on the output.

## Interface
- `CountWidth`, 10: window-count field width; must be ≤10.
- `ValArrayWidth`, 4: array columns W.
- `ValArrayHeight`, 2: array rows H; must be ≥2.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `data_i`  in  16  command word in Idle, parameter/value data otherwise; the core also receives it directly.
- `acc_result_i`  in  16  core accumulate result (fp_t), used combinationally.
- `param_write_o`  out  W*H  one-hot parameter write strobe.
- `val_shift_o`  out  H  one-hot row value-shift strobe.
- `mul_row_sel_o`  out  max(1,$clog2(H))  multiplier row select.
- `mul_en_o`  out  1  multiplier enable.
- `acc_en_o`  out  1  accumulate enable.
- `busy_o`  out  1  high whenever state ≠ Idle.
- `data_o`  out  8  result byte stream.

## Operation
- Command word fields: [15:12] op, [11] K (keep params), [10] R (ReLU), [CountWidth-1:0] N. Op 4'h1 = convolve. All other ops are ignored and the block stays in Idle.
- State machine: Idle, ParamIn, Exec. Every register resets to: Idle, param_write 0, row r 0, counter 0, relu flag 0, params_valid 0.
- Idle + convolve:
  - Latch N into the counter, R into the relu flag, and set r=0.
  - If K=1 and params_valid=1, go to Exec.
  - Otherwise go to ParamIn with param_write=1 (bit0).
- ParamIn: one param_write bit is high per cycle, shifting left each cycle. In the cycle where the MSB is high, the next state is Exec, param_write clears, and params_valid is set.
- Exec:
  - Row counter r steps 0..H-1 and wraps.
  - At r==H-1: if counter≠0, decrement it; else go to Idle.
  - Total Exec cycles = (N+1)*H.
- Exec outputs (all are 0 outside Exec):
  - val_shift_o = 1<<r.
  - mul_row_sel_o = r.
  - mul_en_o = 1.
  - acc_en_o = (r==H-1).
- data_o:
  - 8'hFF outside Exec.
  - In Exec: r==0 gives acc_result_i[15:8]; r==1 gives acc_result_i[7:0]; r≥2 gives 8'h00.
- ReLU: when the relu flag is set and acc_result_i[15]==1, both result bytes read 8'h00.
- params_valid clears only on reset. K=1 before any load falls back to a full ParamIn.

## Timing
- A command sampled at edge E produces its first ParamIn (or Exec) cycle at E+1. busy_o rises at E+1.
- ParamIn lasts exactly W*H cycles. The data_i word present during param_write bit i is parameter i.
- Exec follows ParamIn with no gap.
- After the final Exec cycle, the state is Idle on the next cycle, and data_i is decoded as a command in that same cycle (back-to-back commands, no bubble).
- All control outputs are decoded from registered state only, with no data_i→control combinational path. The data_o path is combinational from acc_result_i.
- Reset asserted mid-ParamIn or mid-Exec has these effects:
  - All outputs go to their reset values immediately: data_o 8'hFF, all others 0.
  - params_valid clears.
  - A partially loaded parameter set is discarded.
- N=0 gives exactly one window (H cycles). N=2^CountWidth-1 must not overflow or wrap the counter.

## Configuration
- `TINY_NN_RELU_EN`:
  - Defined: R bit honoured as above.
  - Undefined: R is ignored, the relu flag is not implemented (tied 0), and output is always the raw result bytes.

## Test plan
- W=4,H=2, command 16'h1003:
  - 8 ParamIn cycles with param_write_o 0x01→0x80.
  - Then 8 Exec cycles, val_shift_o alternating 01/10 and acc_en_o on odd cycles.
  - data_o = hi/lo of acc_result_i; busy_o drops after cycle 17.
- After the above, command 16'h1801 (K=1): Exec starts next cycle with no ParamIn and lasts 4 cycles.
- K=1 straight after reset (16'h1800): full 8-cycle ParamIn still occurs.
- With macro defined, command 16'h1400 with acc_result_i=16'hC120: data_o 00,00. With acc_result_i=16'h4120: data_o 41,20. Without macro, the first case gives C1,20.
- H=3 build, command 16'h1001:
  - 12 ParamIn cycles, then 6 Exec cycles with mul_row_sel_o 0,1,2,0,1,2.
  - data_o hi,lo,00 repeating.
  - Op 4'h7 is ignored and busy_o stays low.
- Reset pulsed mid-Exec: all outputs return to reset values asynchronously. A following K=1 command performs a full ParamIn.

Source files
------------

// File: rtl/tiny_nn_ctrl.sv
// Command sequencer for the tiny-nn value/parameter array core.
// Optional output ReLU is built when TINY_NN_RELU_EN is defined.
module tiny_nn_ctrl #(
    parameter int CountWidth     = 10,
    parameter int ValArrayWidth  = 4,
    parameter int ValArrayHeight = 2,
    localparam int PW = ValArrayWidth * ValArrayHeight,
    localparam int RW = (ValArrayHeight > 2) ? $clog2(ValArrayHeight) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [15:0]               data_i,
    input  logic [15:0]               acc_result_i,
    output logic [PW-1:0]             param_write_o,
    output logic [ValArrayHeight-1:0] val_shift_o,
    output logic [RW-1:0]             mul_row_sel_o,
    output logic                      mul_en_o,
    output logic                      acc_en_o,
    output logic                      busy_o,
    output logic [7:0]                data_o
);

    typedef enum logic [1:0] {
        Idle    = 2'd0,
        ParamIn = 2'd1,
        Exec    = 2'd2
    } state_e;

    localparam logic [RW-1:0] LastRow = RW'(ValArrayHeight - 1);

    state_e                state_q, state_d;
    logic [PW-1:0]         pw_q, pw_d;
    logic [RW-1:0]         row_q, row_d;
    logic [CountWidth-1:0] cnt_q, cnt_d;
    logic                  pvalid_q, pvalid_d;
    logic                  relu_q;
    logic                  is_conv;
    logic                  exec;
    logic                  zero_out;
    logic                  unused_data;

    assign is_conv     = (data_i[15:12] == 4'h1);
    assign exec        = (state_q == Exec);
    assign unused_data = ^data_i;

`ifdef TINY_NN_RELU_EN
    logic relu_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            relu_q <= 1'b0;
        end else begin
            relu_q <= relu_d;
        end
    end

    always_comb begin
        relu_d = relu_q;
        if (state_q == Idle && is_conv) begin
            relu_d = data_i[10];
        end
    end
`else
    assign relu_q = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= Idle;
            pw_q     <= '0;
            row_q    <= '0;
            cnt_q    <= '0;
            pvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pw_q     <= pw_d;
            row_q    <= row_d;
            cnt_q    <= cnt_d;
            pvalid_q <= pvalid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pw_d     = pw_q;
        row_d    = row_q;
        cnt_d    = cnt_q;
        pvalid_d = pvalid_q;
        unique case (state_q)
            Idle: begin
                if (is_conv) begin
                    cnt_d = data_i[CountWidth-1:0];
                    row_d = '0;
                    if (data_i[11] && pvalid_q) begin
                        state_d = Exec;
                    end else begin
                        state_d = ParamIn;
                        pw_d    = PW'(1);
                    end
                end
            end
            ParamIn: begin
                if (pw_q[PW-1]) begin
                    state_d  = Exec;
                    pw_d     = '0;
                    pvalid_d = 1'b1;
                end else begin
                    pw_d = pw_q << 1;
                end
            end
            Exec: begin
                if (row_q == LastRow) begin
                    row_d = '0;
                    // Counter holds at zero on exit, so the max N never wraps.
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CountWidth'(1);
                    end else begin
                        state_d = Idle;
                    end
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            default: state_d = Idle;
        endcase
    end

    assign param_write_o = pw_q;
    assign val_shift_o   = exec ? (ValArrayHeight'(1) << row_q) : '0;
    assign mul_row_sel_o = exec ? row_q : '0;
    assign mul_en_o      = exec;
    assign acc_en_o      = exec && (row_q == LastRow);
    assign busy_o        = (state_q != Idle);
    assign zero_out      = relu_q && acc_result_i[15];

    always_comb begin
        data_o = 8'hFF;
        if (exec) begin
            if (row_q == RW'(0)) begin
                data_o = zero_out ? 8'h00 : acc_result_i[15:8];
            end else if (row_q == RW'(1)) begin
                data_o = zero_out ? 8'h00 : acc_result_i[7:0];
            end else begin
                data_o = 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_tiny_nn_ctrl.sv
// Directed bench for tiny_nn_ctrl: W=4/H=2 instance plus a
// W=4/H=3/CountWidth=3 instance for row-count and max-N cases.
module tb_tiny_nn_ctrl;

    logic clk_i;
    logic rst_ni;

    logic [15:0] a_data_i, a_acc_i;
    logic [7:0]  a_pw;
    logic [1:0]  a_vs;
    logic        a_sel;
    logic        a_mul, a_acc, a_busy;
    logic [7:0]  a_dout;

    logic [15:0] b_data_i, b_acc_i;
    logic [11:0] b_pw;
    logic [2:0]  b_vs;
    logic [1:0]  b_sel;
    logic        b_mul, b_acc, b_busy;
    logic [7:0]  b_dout;

    int errors = 0;
    int checks = 0;

    tiny_nn_ctrl #(
        .CountWidth(10), .ValArrayWidth(4), .ValArrayHeight(2)
    ) u_a (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .data_i(a_data_i), .acc_result_i(a_acc_i),
        .param_write_o(a_pw), .val_shift_o(a_vs),
        .mul_row_sel_o(a_sel), .mul_en_o(a_mul),
        .acc_en_o(a_acc), .busy_o(a_busy), .data_o(a_dout)
    );

    tiny_nn_ctrl #(
        .CountWidth(3), .ValArrayWidth(4), .ValArrayHeight(3)
    ) u_b (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .data_i(b_data_i), .acc_result_i(b_acc_i),
        .param_write_o(b_pw), .val_shift_o(b_vs),
        .mul_row_sel_o(b_sel), .mul_en_o(b_mul),
        .acc_en_o(b_acc), .busy_o(b_busy), .data_o(b_dout)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic a_idle_chk(input string tag);
        chk({tag, ".busy"}, 32'(a_busy), 32'd0);
        chk({tag, ".pw"},   32'(a_pw),   32'd0);
        chk({tag, ".vs"},   32'(a_vs),   32'd0);
        chk({tag, ".sel"},  32'(a_sel),  32'd0);
        chk({tag, ".mul"},  32'(a_mul),  32'd0);
        chk({tag, ".acc"},  32'(a_acc),  32'd0);
        chk({tag, ".dout"}, 32'(a_dout), 32'hFF);
    endtask

    // Called at a negedge in Idle; returns at the negedge after busy drops.
    task automatic run_a(input logic [15:0] cmd, input bit par,
                         input int n, input logic [15:0] acc,
                         input logic [7:0] hi, input logic [7:0] lo);
        a_data_i = cmd;
        a_acc_i  = acc;
        @(negedge clk_i);
        if (par) begin
            for (int i = 0; i < 8; i++) begin
                chk("a.pin.pw",   32'(a_pw),   32'(1) << i);
                chk("a.pin.busy", 32'(a_busy), 32'd1);
                chk("a.pin.mul",  32'(a_mul),  32'd0);
                chk("a.pin.dout", 32'(a_dout), 32'hFF);
                a_data_i = 16'hA000 + 16'(i);
                @(negedge clk_i);
            end
        end
        a_data_i = 16'h0000;
        for (int j = 0; j < (n + 1) * 2; j++) begin
            chk("a.ex.pw",   32'(a_pw),   32'd0);
            chk("a.ex.busy", 32'(a_busy), 32'd1);
            chk("a.ex.vs",   32'(a_vs),   (j % 2 == 0) ? 32'd1 : 32'd2);
            chk("a.ex.sel",  32'(a_sel),  32'(j % 2));
            chk("a.ex.mul",  32'(a_mul),  32'd1);
            chk("a.ex.acc",  32'(a_acc),  32'(j % 2));
            chk("a.ex.dout", 32'(a_dout), (j % 2 == 0) ? 32'(hi) : 32'(lo));
            @(negedge clk_i);
        end
        a_idle_chk("a.end");
    endtask

    initial begin
        rst_ni   = 1'b0;
        a_data_i = 16'h0;
        a_acc_i  = 16'h0;
        b_data_i = 16'h0;
        b_acc_i  = 16'h0;
        #12;
        a_idle_chk("rst");
        chk("rst.b.busy", 32'(b_busy), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // K=1 with no parameters loaded yet: full load expected.
        run_a(16'h1800, 1'b1, 0, 16'h1234, 8'h12, 8'h34);
        run_a(16'h1003, 1'b1, 3, 16'hBEEF, 8'hBE, 8'hEF);
        run_a(16'h1801, 1'b0, 1, 16'h5A3C, 8'h5A, 8'h3C);

`ifdef TINY_NN_RELU_EN
        run_a(16'h1C00, 1'b0, 0, 16'hC120, 8'h00, 8'h00);
`else
        run_a(16'h1C00, 1'b0, 0, 16'hC120, 8'hC1, 8'h20);
`endif
        run_a(16'h1C00, 1'b0, 0, 16'h4120, 8'h41, 8'h20);
        // ReLU flag is relatched per command; R=0 passes negatives.
        run_a(16'h1800, 1'b0, 0, 16'hC120, 8'hC1, 8'h20);

        a_data_i = 16'h7003;
        @(negedge clk_i);
        chk("a.op7.busy1", 32'(a_busy), 32'd0);
        @(negedge clk_i);
        chk("a.op7.busy2", 32'(a_busy), 32'd0);
        a_data_i = 16'h0;
        @(negedge clk_i);

        // H=3, CountWidth=3, N=7 is the max count: 8 windows.
        b_data_i = 16'h1007;
        b_acc_i  = 16'h9876;
        @(negedge clk_i);
        for (int i = 0; i < 12; i++) begin
            chk("b.pin.pw",   32'(b_pw),   32'(1) << i);
            chk("b.pin.busy", 32'(b_busy), 32'd1);
            b_data_i = 16'hB000 + 16'(i);
            @(negedge clk_i);
        end
        b_data_i = 16'h0;
        for (int j = 0; j < 24; j++) begin
            chk("b.ex.sel",  32'(b_sel),  32'(j % 3));
            chk("b.ex.vs",   32'(b_vs),   32'(1) << (j % 3));
            chk("b.ex.acc",  32'(b_acc),  32'(j % 3 == 2));
            chk("b.ex.busy", 32'(b_busy), 32'd1);
            chk("b.ex.dout", 32'(b_dout),
                (j % 3 == 0) ? 32'h98 : (j % 3 == 1) ? 32'h76 : 32'h00);
            @(negedge clk_i);
        end
        chk("b.end.busy", 32'(b_busy), 32'd0);
        chk("b.end.dout", 32'(b_dout), 32'hFF);
        b_data_i = 16'h7001;
        @(negedge clk_i);
        chk("b.op7.busy", 32'(b_busy), 32'd0);
        b_data_i = 16'h0;

        // Asynchronous reset mid-Exec.
        a_data_i = 16'h1803;
        a_acc_i  = 16'h1357;
        @(negedge clk_i);
        a_data_i = 16'h0;
        @(negedge clk_i);
        chk("a.mid.busy", 32'(a_busy), 32'd1);
        chk("a.mid.acc",  32'(a_acc),  32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        a_idle_chk("a.arst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        run_a(16'h1800, 1'b1, 0, 16'h2468, 8'h24, 8'h68);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
